// File: rtl/div8_seq.sv
// div8_seq: sequential 8-bit restoring divider, one quotient bit per cycle, start/busy/done handshake.
// Define DIV8_SIGNED_EN to add Signed_Mode (two's complement, truncation toward zero).
module div8_seq #(
  parameter int    UUID = 0,
  parameter string NAME = ""
) (
  input  logic       clk,
  input  logic       rst,
`ifdef DIV8_SIGNED_EN
  input  logic       Signed_Mode,
`endif
  input  logic       Start,
  input  logic [7:0] Dividend,
  input  logic [7:0] Divisor,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Quotient,
  output logic [7:0] Remainder,
  output logic       Div_By_Zero
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  if (UUID < 0 && $bits(NAME) < 0) begin : g_id
  end
  logic [1:0] state;
  logic [2:0] cnt;
  logic [7:0] dvd, dvs, mag_a, mag_b, qn;
  logic [8:0] rem, sh, nrem;
  logic [9:0] diff;
  logic       neg_q, neg_r, sm;
`ifdef DIV8_SIGNED_EN
  assign sm = Signed_Mode;
`else
  assign sm = 1'b0;
`endif
  // Signed operands are divided as magnitudes; signs are reapplied on the DONE write.
  assign mag_a = (sm && Dividend[7]) ? -Dividend : Dividend;
  assign mag_b = (sm && Divisor[7]) ? -Divisor : Divisor;
  assign sh    = {rem[7:0], dvd[7]};
  assign diff  = {1'b0, sh} - {2'b00, dvs};
  assign nrem  = diff[9] ? sh : diff[8:0];
  assign qn    = {dvd[6:0], ~diff[9]};
  assign Busy  = state == CALC;
  assign Done  = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      dvd         <= 8'd0;
      dvs         <= 8'd0;
      rem         <= 9'd0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      Quotient    <= 8'd0;
      Remainder   <= 8'd0;
      Div_By_Zero <= 1'b0;
    end else if (state != CALC && Start) begin
      if (Divisor == 8'd0) begin
        state       <= DONE;
        Quotient    <= 8'hFF;
        Remainder   <= Dividend;
        Div_By_Zero <= 1'b1;
      end else begin
        state <= CALC;
        cnt   <= 3'd0;
        rem   <= 9'd0;
        dvd   <= mag_a;
        dvs   <= mag_b;
        neg_q <= sm && (Dividend[7] ^ Divisor[7]);
        neg_r <= sm && Dividend[7];
      end
    end else if (state == CALC) begin
      rem <= nrem;
      dvd <= qn;
      cnt <= cnt + 3'd1;
      if (cnt == 3'd7) begin
        state       <= DONE;
        Quotient    <= neg_q ? -qn : qn;
        Remainder   <= neg_r ? -nrem[7:0] : nrem[7:0];
        Div_By_Zero <= 1'b0;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_div8_seq.sv
// tb_div8_seq: directed checks of div8_seq against a cycle-level arithmetic model.
module tb_div8_seq;
  logic       clk = 1'b0, rst = 1'b1, Start = 1'b0;
  logic [7:0] Dividend = 8'd0, Divisor = 8'd0;
  logic       Busy, Done, Div_By_Zero;
  logic [7:0] Quotient, Remainder;
  bit         sm = 1'b0;
  int         checks = 0, errors = 0;

  div8_seq #(.UUID(3), .NAME("div")) dut (
    .clk(clk), .rst(rst),
`ifdef DIV8_SIGNED_EN
    .Signed_Mode(sm),
`endif
    .Start(Start), .Dividend(Dividend), .Divisor(Divisor),
    .Busy(Busy), .Done(Done), .Quotient(Quotient), .Remainder(Remainder),
    .Div_By_Zero(Div_By_Zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: busy countdown plus arithmetic results, no knowledge of the datapath.
  int         left = 0;
  bit         armed = 0, m_done = 0, m_z = 0, p_z = 0;
  logic [7:0] m_q = 0, m_r = 0, p_q = 0, p_r = 0;
  always @(posedge clk) begin
    int sa, sb;
    if (rst) begin
      armed = 1; left = 0; m_done = 0; m_q = 0; m_r = 0; m_z = 0;
    end else begin
      m_done = 0;
      if (left > 0) begin
        left--;
        if (left == 0) begin m_done = 1; m_q = p_q; m_r = p_r; m_z = p_z; end
      end else if (Start) begin
        if (Divisor == 0) begin
          m_done = 1; m_q = 8'hFF; m_r = Dividend; m_z = 1;
        end else begin
          sa = sm ? int'($signed(Dividend)) : int'(Dividend);
          sb = sm ? int'($signed(Divisor)) : int'(Divisor);
          p_q = 8'(sa / sb); p_r = 8'(sa % sb); p_z = 0; left = 8;
        end
      end
    end
  end

  always @(negedge clk) if (armed) begin
    chk("busy", Busy, left > 0);
    chk("done", Done, m_done);
    chk("quot", Quotient, m_q);
    chk("rem", Remainder, m_r);
    chk("dbz", Div_By_Zero, m_z);
  end

  task automatic run(input logic [7:0] a, input logic [7:0] b, input bit s,
                     input logic [7:0] eq, input logic [7:0] er, input logic ez, input int lat);
    int n;
    @(negedge clk); Dividend = a; Divisor = b; sm = s; Start = 1;
    @(negedge clk); Start = 0; n = 1;
    while (!Done && n < 20) begin @(negedge clk); n++; end
    chk("latency", n, lat);
    chk("lit_quot", Quotient, eq);
    chk("lit_rem", Remainder, er);
    chk("lit_dbz", Div_By_Zero, ez);
  endtask

  initial begin
    int n, dn;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_quot", Quotient, 0);
    chk("rst_rem", Remainder, 0);
    chk("rst_dbz", Div_By_Zero, 0);
    run(8'd200, 8'd7, 0, 8'h1C, 8'd4, 0, 9);
    run(8'h05, 8'h00, 0, 8'hFF, 8'h05, 1, 1);
    run(8'd255, 8'd1, 0, 8'd255, 8'd0, 0, 9);
    run(8'd0, 8'd9, 0, 8'd0, 8'd0, 0, 9);
    run(8'd255, 8'd255, 0, 8'd1, 8'd0, 0, 9);
    run(8'd3, 8'd200, 0, 8'd0, 8'd3, 0, 9);
    // Start held through CALC with new operands; relaunches from DONE.
    @(negedge clk); Dividend = 8'd100; Divisor = 8'd3; Start = 1;
    @(negedge clk); Dividend = 8'd50; Divisor = 8'd5; n = 1;
    while (!Done && n < 20) begin @(negedge clk); n++; end
    chk("held_latency", n, 9);
    chk("held_quot", Quotient, 8'd33);
    chk("held_rem", Remainder, 8'd1);
    @(negedge clk); Start = 0; n = 1;
    while (!Done && n < 20) begin @(negedge clk); n++; end
    chk("b2b_latency", n, 9);
    chk("b2b_quot", Quotient, 8'd10);
    chk("b2b_rem", Remainder, 8'd0);
    // Reset in the fourth CALC cycle aborts with no Done.
    @(negedge clk); Dividend = 8'd200; Divisor = 8'd7; Start = 1;
    @(negedge clk); Start = 0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", Busy, 1);
    rst = 1;
    @(negedge clk); rst = 0;
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_quot", Quotient, 0);
    chk("abort_rem", Remainder, 0);
    dn = 0;
    repeat (12) begin @(negedge clk); dn += int'(Done); end
    chk("abort_no_done", dn, 0);
`ifdef DIV8_SIGNED_EN
    run(8'hF9, 8'h02, 1, 8'hFD, 8'hFF, 0, 9);
    run(8'h80, 8'hFF, 1, 8'h80, 8'h00, 0, 9);
    run(8'h80, 8'h00, 1, 8'hFF, 8'h80, 1, 1);
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
